// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Optional forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 3;
    localparam int NUM_WR_DEF   = 2;
    localparam int IMM_W_DEF    = 12;
    localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

    localparam logic [DATA_W_DEF-1:0] SP_RESET_DEF = 64'h80000;

    typedef logic [AW_DEF-1:0]     reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve bus of the register file; master is decode/issue plus
// writeback, slave is the register file itself.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int IMM_W    = IMM_W_DEF
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD-1:0]        rd_imm_sel;
    logic [NUM_RD*IMM_W-1:0]  rd_imm;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic [DATA_W-1:0]        sp_val;

    modport master (
        output rd_addr, rd_imm_sel, rd_imm, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, sp_val
    );

    modport slave (
        input  rd_addr, rd_imm_sel, rd_imm, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, sp_val
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One read port: immediate override, optional same-cycle write forwarding
// (REGFILE_BYPASS_EN) and busy gating.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF,
    parameter int NUM_WR = NUM_WR_DEF,
    parameter int IMM_W  = IMM_W_DEF
) (
`ifdef REGFILE_BYPASS_EN
    input  logic [AW-1:0]            rd_addr_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [AW-1:0]            rsv_addr_i,
`endif
    input  logic                     imm_sel_i,
    input  logic [IMM_W-1:0]         imm_i,
    input  logic [DATA_W-1:0]        reg_data_i,
    input  logic                     reg_busy_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_busy_o
);

`ifdef REGFILE_BYPASS_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Later ports overwrite earlier matches, so the highest index wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data_i[w*DATA_W +: DATA_W];
            end
        end
    end
`endif

    always_comb begin
        rd_data_o = reg_data_i;
        rd_busy_o = reg_busy_i;
`ifdef REGFILE_BYPASS_EN
        if (fwd_hit) begin
            rd_data_o = fwd_data;
            if (!(rsv_en_i && (rsv_addr_i == rd_addr_i))) begin
                rd_busy_o = 1'b0;
            end
        end
`endif
        if (imm_sel_i) begin
            rd_data_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard for the issue stage.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                NUM_REGS = NUM_REGS_DEF,
    parameter int                NUM_RD   = NUM_RD_DEF,
    parameter int                NUM_WR   = NUM_WR_DEF,
    parameter int                IMM_W    = IMM_W_DEF,
    parameter int                SP_IDX   = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEF
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [DATA_W-1:0]   rd_data_a [NUM_RD];
    logic [NUM_RD-1:0]   rd_busy_a;

    // Write ports applied in index order so the highest one wins; the reserve
    // is applied last so a back-to-back producer keeps its register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w]) begin
                regs_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*DATA_W +: DATA_W];
                busy_d[bus.wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (bus.rsv_en) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Nothing may be forwarded while reset holds the array at its reset values.
    logic [NUM_WR-1:0] fwd_en;
    logic              fwd_rsv;
    assign fwd_en  = bus.wr_en & {NUM_WR{~reset}};
    assign fwd_rsv = bus.rsv_en & ~reset;
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = bus.rd_addr[p*AW +: AW];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NUM_WR (NUM_WR),
            .IMM_W  (IMM_W)
        ) u_rd (
`ifdef REGFILE_BYPASS_EN
            .rd_addr_i  (addr),
            .wr_en_i    (fwd_en),
            .wr_addr_i  (bus.wr_addr),
            .wr_data_i  (bus.wr_data),
            .rsv_en_i   (fwd_rsv),
            .rsv_addr_i (bus.rsv_addr),
`endif
            .imm_sel_i  (bus.rd_imm_sel[p]),
            .imm_i      (bus.rd_imm[p*IMM_W +: IMM_W]),
            .reg_data_i (regs_q[addr]),
            .reg_busy_i (busy_q[addr]),
            .rd_data_o  (rd_data_a[p]),
            .rd_busy_o  (rd_busy_a[p])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd_data[p*DATA_W +: DATA_W] = rd_data_a[p];
        end
    end

    assign bus.rd_busy = rd_busy_a;
    assign bus.sp_val  = regs_q[SP_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table through a scoreboard queue,
// plus reset and mid-cycle reset sequences. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_mp_if bus ();

    regfile_mp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wr_en;
        reg_addr_t   wa0, wa1;
        logic [63:0] wd0, wd1;
        logic        rsv;
        reg_addr_t   ra;
        reg_addr_t   a0, a1, a2;
        logic        i2;
        logic [11:0] imm2;
        logic [63:0] e0_nb, e0_by, e1, e2;
        logic [2:0]  eb_nb, eb_by;
        logic [63:0] esp;
    } vec_t;

    typedef struct {
        logic [63:0] d0, d1, d2;
        logic [2:0]  busy;
        logic [63:0] sp;
    } exp_t;

    vec_t vt [18];
    exp_t sbq [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rsv_en     = 1'b0;
        bus.rsv_addr   = '0;
        bus.rd_imm_sel = '0;
        bus.rd_imm     = '0;
        bus.rd_addr    = '0;
    endtask

    task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2);
        bus.rd_addr    = {a2, a1, a0};
        bus.rd_imm_sel = '0;
    endtask

    task automatic drive(input vec_t v);
        bus.wr_en      = v.wr_en;
        bus.wr_addr    = {v.wa1, v.wa0};
        bus.wr_data    = {v.wd1, v.wd0};
        bus.rsv_en     = v.rsv;
        bus.rsv_addr   = v.ra;
        bus.rd_addr    = {v.a2, v.a1, v.a0};
        bus.rd_imm_sel = {v.i2, 2'b00};
        bus.rd_imm     = {v.imm2, 24'h0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        //        wr_en  wa0  wa1  wd0            wd1      rsv   ra   a0   a1   a2   i2   imm     e0_nb          e0_by          e1             e2        eb_nb   eb_by   esp
        vt[0]  = '{2'b01, 5'd5, 5'd0, 64'hDEADBEEF, 64'h0,  1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 12'hFFF, 64'h0,         64'hDEADBEEF, 64'h0,         64'hFFF,   3'b000, 3'b000, 64'h80000};
        vt[1]  = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd5, 5'd5, 5'd0, 1'b1, 12'hFFF, 64'hDEADBEEF, 64'hDEADBEEF, 64'hDEADBEEF, 64'hFFF,   3'b000, 3'b000, 64'h80000};
        vt[2]  = '{2'b11, 5'd7, 5'd7, 64'h11,       64'h22, 1'b0, 5'd0, 5'd7, 5'd5, 5'd31,1'b0, 12'h0,   64'h0,         64'h22,        64'hDEADBEEF, 64'h80000, 3'b000, 3'b000, 64'h80000};
        vt[3]  = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd7, 5'd7, 5'd0, 1'b1, 12'h123, 64'h22,        64'h22,        64'h22,        64'h123,   3'b000, 3'b000, 64'h80000};
        vt[4]  = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b1, 5'd9, 5'd9, 5'd9, 5'd0, 1'b0, 12'h0,   64'h0,         64'h0,         64'h0,         64'h0,     3'b000, 3'b000, 64'h80000};
        vt[5]  = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 1'b1, 12'hABC, 64'h0,         64'h0,         64'h0,         64'hABC,   3'b011, 3'b011, 64'h80000};
        vt[6]  = '{2'b10, 5'd0, 5'd9, 64'h0,        64'h55, 1'b0, 5'd0, 5'd9, 5'd0, 5'd31,1'b0, 12'h0,   64'h0,         64'h55,        64'h0,         64'h80000, 3'b001, 3'b000, 64'h80000};
        vt[7]  = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 5'd0, 1'b0, 12'h0,   64'h55,        64'h55,        64'h55,        64'h0,     3'b000, 3'b000, 64'h80000};
        vt[8]  = '{2'b01, 5'd9, 5'd0, 64'h55,       64'h0,  1'b1, 5'd9, 5'd9, 5'd9, 5'd0, 1'b0, 12'h0,   64'h55,        64'h55,        64'h55,        64'h0,     3'b000, 3'b000, 64'h80000};
        vt[9]  = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 1'b1, 12'h001, 64'h55,        64'h55,        64'h55,        64'h1,     3'b011, 3'b011, 64'h80000};
        vt[10] = '{2'b01, 5'd3, 5'd0, 64'hABC,      64'h0,  1'b0, 5'd0, 5'd3, 5'd9, 5'd0, 1'b0, 12'h0,   64'h0,         64'hABC,       64'h55,        64'h0,     3'b010, 3'b010, 64'h80000};
        vt[11] = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd3, 5'd3, 5'd0, 1'b0, 12'h0,   64'hABC,       64'hABC,       64'hABC,       64'h0,     3'b000, 3'b000, 64'h80000};
        vt[12] = '{2'b01, 5'd31,5'd0, 64'h1234,     64'h0,  1'b0, 5'd0, 5'd31,5'd0, 5'd0, 1'b0, 12'h0,   64'h80000,     64'h1234,      64'h0,         64'h0,     3'b000, 3'b000, 64'h80000};
        vt[13] = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd31,5'd31,5'd0, 1'b0, 12'h0,   64'h1234,      64'h1234,      64'h1234,      64'h0,     3'b000, 3'b000, 64'h1234};
        vt[14] = '{2'b11, 5'd1, 5'd2, 64'hA1,       64'hB2, 1'b0, 5'd0, 5'd1, 5'd31,5'd0, 1'b0, 12'h0,   64'h0,         64'hA1,        64'h1234,      64'h0,     3'b000, 3'b000, 64'h1234};
        vt[15] = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 12'h0,   64'hA1,        64'hA1,        64'hB2,        64'h0,     3'b000, 3'b000, 64'h1234};
        vt[16] = '{2'b01, 5'd9, 5'd0, 64'h66,       64'h0,  1'b1, 5'd4, 5'd9, 5'd4, 5'd0, 1'b0, 12'h0,   64'h55,        64'h66,        64'h0,         64'h0,     3'b001, 3'b000, 64'h1234};
        vt[17] = '{2'b00, 5'd0, 5'd0, 64'h0,        64'h0,  1'b0, 5'd0, 5'd9, 5'd4, 5'd0, 1'b0, 12'h0,   64'h66,        64'h66,        64'h0,         64'h0,     3'b010, 3'b010, 64'h1234};

        // Reset held, checked before any clock edge.
        reset = 1'b1;
        idle();
        set_rd(5'd31, 5'd12, 5'd0);
        #2;
        chk("rst_hold_p0_sp", bus.rd_data[63:0], 64'h80000);
        chk("rst_hold_p1",    bus.rd_data[127:64], 64'h0);
        chk("rst_hold_busy",  {61'h0, bus.rd_busy}, 64'h0);
        chk("rst_hold_spval", bus.sp_val, 64'h80000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            set_rd(reg_addr_t'(a), reg_addr_t'(31 - a), reg_addr_t'(a));
            #1;
            chk($sformatf("rst_p0_r%0d", a), bus.rd_data[63:0], (a == 31) ? 64'h80000 : 64'h0);
            chk($sformatf("rst_p1_r%0d", 31 - a), bus.rd_data[127:64], (a == 0) ? 64'h80000 : 64'h0);
            chk($sformatf("rst_busy_%0d", a), {61'h0, bus.rd_busy}, 64'h0);
        end
        chk("rst_spval", bus.sp_val, 64'h80000);

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            e.d0   = BYP ? vt[i].e0_by : vt[i].e0_nb;
            e.d1   = vt[i].e1;
            e.d2   = vt[i].e2;
            e.busy = BYP ? vt[i].eb_by : vt[i].eb_nb;
            e.sp   = vt[i].esp;
            sbq.push_back(e);
            @(negedge clk);
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL vec%0d_sb: got empty queue want entry", i);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("vec%0d_d0", i), bus.rd_data[63:0], e.d0);
                chk($sformatf("vec%0d_d1", i), bus.rd_data[127:64], e.d1);
                chk($sformatf("vec%0d_d2", i), bus.rd_data[191:128], e.d2);
                chk($sformatf("vec%0d_busy", i), {61'h0, bus.rd_busy}, {61'h0, e.busy});
                chk($sformatf("vec%0d_sp", i), bus.sp_val, e.sp);
            end
        end

        // Mid-cycle asynchronous reset with a write pending.
        @(posedge clk);
        #1;
        idle();
        bus.wr_en    = 2'b01;
        bus.wr_addr  = {5'd0, 5'd12};
        bus.wr_data  = {64'h0, 64'h77};
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd12;
        @(posedge clk);
        #1;
        idle();
        set_rd(5'd12, 5'd31, 5'd0);
        #1;
        chk("mid_pre_d0", bus.rd_data[63:0], 64'h77);
        chk("mid_pre_busy", {63'h0, bus.rd_busy[0]}, 64'h1);
        bus.wr_en   = 2'b01;
        bus.wr_addr = {5'd0, 5'd12};
        bus.wr_data = {64'h0, 64'h99};
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_d0", bus.rd_data[63:0], 64'h0);
        chk("mid_rst_busy", {61'h0, bus.rd_busy}, 64'h0);
        chk("mid_rst_p1_sp", bus.rd_data[127:64], 64'h80000);
        chk("mid_rst_spval", bus.sp_val, 64'h80000);
        @(posedge clk);
        #1;
        chk("mid_rst_edge_d0", bus.rd_data[63:0], 64'h0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        set_rd(5'd12, 5'd31, 5'd0);
        @(posedge clk);
        #1;
        chk("post_rst_d0", bus.rd_data[63:0], 64'h0);
        bus.wr_en   = 2'b01;
        bus.wr_addr = {5'd0, 5'd12};
        bus.wr_data = {64'h0, 64'h5};
        @(posedge clk);
        #1;
        idle();
        set_rd(5'd12, 5'd31, 5'd0);
        #1;
        chk("post_rst_wr_d0", bus.rd_data[63:0], 64'h5);
        chk("post_rst_spval", bus.sp_val, 64'h80000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; successor to the single-write, two-read register file.
- Configurable data width, register count and read/write port count.
- Per-port immediate override, write-through forwarding and a busy scoreboard for the issue stage.
- Sits between decode/issue (read, reserve) and writeback (write, release).

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, number of registers; power of two, >= 2.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports.
- IMM_W, 12, immediate width for read-port override.
- SP_IDX, NUM_REGS-1, index of the stack-pointer register.
- SP_RESET, 64'h80000, reset value of register SP_IDX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; AW = $clog2(NUM_REGS).
- rd_imm_sel  in  NUM_RD  per-port immediate override select.
- rd_imm  in  NUM_RD*IMM_W  packed immediates.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  addressed register has an outstanding reservation (always 0 when imm selected).
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- rsv_en  in  1  reserve destination (mark busy).
- rsv_addr  in  AW  register to reserve.
- sp_val  out  DATA_W  current value of register SP_IDX (registered state, no forwarding).

Behaviour:
- Reset (async assert, sync-released use):
  - regs[SP_IDX] = SP_RESET; all other regs = 0; busy[] = 0.
  - During reset: rd_data = 0, or SP_RESET for ports addressing SP_IDX; rd_busy = 0; sp_val = SP_RESET.
- Reads are combinational, zero latency:
  - rd_imm_sel[p]=1 -> rd_data[p] = zero-extended rd_imm[p]; rd_busy[p] = 0.
  - Otherwise rd_data[p] = regs[rd_addr[p]], subject to forwarding (see Optional Feature).
- Writes:
  - On posedge, each wr_en[w] writes wr_data[w] into regs[wr_addr[w]].
  - Any write to a register clears its busy bit.
  - Two or more enabled ports with the same address: highest port index wins. Deterministic; not an error.
- Reserve:
  - On posedge, rsv_en sets busy[rsv_addr].
  - Reserve and write of the same register in the same cycle: reserve wins (busy ends 1, data still written). This covers a back-to-back producer.
- rd_busy[p] = busy[rd_addr[p]] as registered state. A write in the current cycle does not clear it combinationally.
- Writes after reset deassert take effect on the first posedge.
- Reset asserted mid-cycle: state returns to reset values immediately, and pending writes in that cycle are discarded.
- No hardwired zero register; every index, including SP_IDX, is writable.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A same-cycle enabled write to rd_addr[p] is forwarded to rd_data[p], highest write-port index winning.
  - rd_busy[p] is forced to 0 when a forwarded write matches and no same-cycle reserve targets that address.
- Undefined:
  - Reads return pre-edge register contents only.
  - rd_busy reflects registered busy bits only.
- sp_val is never forwarded in either mode.

Decomposition:
- Package regfile_pkg:
  - DATA_W / NUM_REGS / IMM_W default constants.
  - SP_RESET default.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef reg_data_t (logic [DATA_W-1:0]).
- Sub-module regfile_rd_port: one read port (imm mux, forwarding priority mux, busy gating), instantiated NUM_RD times via generate.

Test Plan:
- Reset then read all 32 registers -> every rd_data = 0 except addr 31 = 0x80000; sp_val = 0x80000; rd_busy = 0.
- Write port0 addr 5 = 0xDEAD_BEEF, next cycle read port1 addr 5 -> 0xDEADBEEF; rd_imm_sel[2]=1, rd_imm=0xFFF -> rd_data[2] = 0x0000_0000_0000_0FFF.
- Same cycle wr_en=2'b11, both addr 7, data 0x11 (port0) and 0x22 (port1) -> regs[7] = 0x22.
- Scoreboard sequence:
  - rsv_en addr 9 -> rd_busy=1 next cycle.
  - Write addr 9 = 0x55 -> busy clears after the edge.
  - Reserve + write addr 9 in the same cycle -> busy stays 1, data 0x55.
- With REGFILE_BYPASS_EN, write addr 3 = 0xABC while reading addr 3 -> rd_data = 0xABC in the same cycle; without the macro -> old value (0).
- Write addr 12 = 0x77, assert reset mid-cycle (asynchronous, between edges) -> rd_data for addr 12 = 0 and busy = 0 immediately; reg 31 = 0x80000.
